// File: rtl/uart_tx_sequencer_pkg.sv
// Shared definitions for the UART transmit sequencer.
// - UART register byte offsets (STAT, CTRL, DATA) relative to the UART base address.
// - Bit index of the transmitter-busy flag inside STAT.
// - 3-bit state encoding of the sequencer FSM.
package uart_tx_sequencer_pkg;

  localparam logic [7:0] UART_STAT = 8'h00;
  localparam logic [7:0] UART_CTRL = 8'h08;
  localparam logic [7:0] UART_DATA = 8'h10;

  localparam int unsigned STAT_BUSY_BIT = 0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdStat = 3'd1,
    StGapRd  = 3'd2,
    StWrData = 3'd3,
    StGapWr  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/uart_tx_sequencer_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset (empties the FIFO)
//   push, din      : write request and data (accepted when not full, or when popping)
//   pop, dout      : read request and head-of-queue data (pop ignored when empty)
//   full, empty    : status flags
module uart_tx_sequencer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Wishbone master sharing the UART transmit path between NUM_REQ byte requesters.
// A round-robin arbiter admits at most one byte per cycle into a FIFO; the FSM polls UART STAT
// and writes UART DATA only while the transmitter is idle, so no byte is silently dropped.
// Optional feature macro: UART_SEQ_CRLF_EN (each 8'h0A is preceded by a write of 8'h0D).
// Ports:
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   req_valid_i/req_data_i  : per-requester byte streams (requester k on bits [8k+7:8k])
//   req_ready_o             : one-hot grant; byte moves when valid & ready
//   wb_*                    : Wishbone master (registered controls, address, write data)
//   busy_o                  : FIFO non-empty or FSM not idle
//   err_o                   : sticky bus error / ack timeout flag, cleared only by reset
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [63:0] UART_BASE   = 64'h0,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned ADR_WIDTH   = 64,
  parameter int unsigned DAT_WIDTH   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADR_WIDTH-1:0] wb_adr_o,
  output logic [DAT_WIDTH-1:0] wb_dat_o,
  input  logic [DAT_WIDTH-1:0] wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  // Counter value on the last cycle a phase may wait; the phase is abandoned at that edge.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);
  localparam logic [ADR_WIDTH-1:0] AdrStat = ADR_WIDTH'(UART_BASE + 64'(UART_STAT));
  localparam logic [ADR_WIDTH-1:0] AdrData = ADR_WIDTH'(UART_BASE + 64'(UART_DATA));

  logic [PtrW-1:0]    rr_ptr_q;
  logic [PtrW-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         push_data;
  logic [7:0]         fifo_head;
  logic [7:0]         wr_byte;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  seq_state_e         state_q;
  logic               uart_busy_q;
  logic [TmoW-1:0]    tmo_q;
  logic               err_q;
  logic               in_phase;
  logic               bus_fail;
  logic               cr_pending;
  logic               unused_dat;

  assign unused_dat = ^wb_dat_i;

  // Round-robin: first valid requester at or after the pointer, none while full or in reset.
  always_comb begin : arb
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    push_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!found && req_valid_i[idx] && !fifo_full && rst_n_i) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PtrW'(idx);
        push_data  = req_data_i[8*idx +: 8];
      end
    end
  end

  assign req_ready_o = grant;
  assign fifo_push   = |grant;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rr_ptr_q <= '0;
    end else if (fifo_push) begin
      rr_ptr_q <= (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  uart_tx_sequencer_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (push_data),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef UART_SEQ_CRLF_EN
  logic cr_sent_q;

  // An LF at the head whose CR has not yet gone out is written as CR first, without popping.
  assign cr_pending = (fifo_head == 8'h0A) && !cr_sent_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cr_sent_q <= 1'b0;
    end else if (fifo_pop) begin
      cr_sent_q <= 1'b0;
    end else if (state_q == StWrData && wb_ack_i && cr_pending) begin
      cr_sent_q <= 1'b1;
    end
  end
`else
  assign cr_pending = 1'b0;
`endif

  assign wr_byte  = cr_pending ? 8'h0D : fifo_head;
  assign in_phase = (state_q == StRdStat) || (state_q == StWrData);
  // An ack on the final cycle still wins over the timeout.
  assign bus_fail = in_phase && (wb_err_i || (tmo_q == TmoLast && !wb_ack_i));
  // Errors discard the head byte (and with it any half-sent CR/LF pair).
  assign fifo_pop = bus_fail || (state_q == StWrData && wb_ack_i && !cr_pending);
  assign busy_o   = !fifo_empty || (state_q != StIdle);
  assign err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      uart_busy_q <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q  <= StRdStat;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= AdrStat;
            tmo_q    <= '0;
          end
        end
        StRdStat, StWrData: begin
          if (bus_fail || wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (bus_fail) begin
              err_q   <= 1'b1;
              state_q <= StGapWr;
            end else if (state_q == StRdStat) begin
              uart_busy_q <= wb_dat_i[STAT_BUSY_BIT];
              state_q     <= StGapRd;
            end else begin
              state_q <= StGapWr;
            end
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        // Strobe stays low here for one cycle so the slave can re-arm.
        StGapRd: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          tmo_q    <= '0;
          if (uart_busy_q) begin
            state_q  <= StRdStat;
            wb_we_o  <= 1'b0;
            wb_adr_o <= AdrStat;
          end else begin
            state_q  <= StWrData;
            wb_we_o  <= 1'b1;
            wb_adr_o <= AdrData;
            wb_dat_o <= DAT_WIDTH'(wr_byte);
          end
        end
        StGapWr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed self-checking bench for uart_tx_sequencer with a small Wishbone UART slave model.
module tb_uart_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        wb_cyc, wb_stb, wb_we;
  logic [63:0] wb_adr, wb_wdat;
  logic [63:0] wb_rdat = 64'h0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        busy, err;

  always #5 clk = ~clk;

  uart_tx_sequencer #(
    .NUM_REQ     (2),
    .FIFO_DEPTH  (8),
    .UART_BASE   (64'h0),
    .ACK_TIMEOUT (255),
    .ADR_WIDTH   (64),
    .DAT_WIDTH   (64)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_we_o     (wb_we),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_wdat),
    .wb_dat_i    (wb_rdat),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err),
    .busy_o      (busy),
    .err_o       (err)
  );

  // Slave model controls (written only by the stimulus block).
  int busy_until    = 0;
  int err_write_idx = -1;
  bit hold_busy     = 1'b0;
  bit no_ack_wr     = 1'b0;

  // Slave model state (written only by the model).
  int         stat_reads  = 0;
  int         wr_attempts = 0;
  int         bad_bus     = 0;
  int         gap_viol    = 0;
  bit         resp_prev   = 1'b0;
  logic [7:0] writes[$];

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
      if (wb_we) begin
        if (!no_ack_wr) begin
          if (wr_attempts == err_write_idx) wb_err <= 1'b1;
          else wb_ack <= 1'b1;
          wr_attempts <= wr_attempts + 1;
        end
      end else begin
        wb_ack  <= 1'b1;
        wb_rdat <= (hold_busy || stat_reads < busy_until) ? 64'h1 : 64'hFFFF_FFFF_FFFF_FFFE;
      end
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
    end
    if (wb_ack && wb_stb && wb_cyc) begin
      if (wb_we) begin
        writes.push_back(wb_wdat[7:0]);
        if (wb_adr !== 64'h10 || wb_wdat[63:8] !== 56'h0) bad_bus <= bad_bus + 1;
      end else begin
        stat_reads <= stat_reads + 1;
        if (wb_adr !== 64'h0) bad_bus <= bad_bus + 1;
      end
    end
    if (resp_prev && wb_stb) gap_viol <= gap_viol + 1;
    resp_prev <= wb_ack || wb_err;
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  int         grants[$];
  logic [7:0] exp_w[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    grants.delete();
  endtask

  // Present queued bytes each cycle; a byte leaves its queue when valid & ready.
  task automatic feed(input int budget);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0) && n < budget) begin
      req_valid = {src1.size() > 0, src0.size() > 0};
      req_data  = {(src1.size() > 0) ? src1[0] : 8'h00, (src0.size() > 0) ? src0[0] : 8'h00};
      #1;
      if (req_valid[0] && req_ready[0]) begin
        grants.push_back(0);
        void'(src0.pop_front());
      end
      if (req_valid[1] && req_ready[1]) begin
        grants.push_back(1);
        void'(src1.pop_front());
      end
      @(negedge clk);
      n++;
    end
    req_valid = '0;
    check("feed_bound", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", 64'(n < budget), 64'd1);
  endtask

  task automatic wait_wr(input int budget);
    int n;
    n = 0;
    while (!(wb_stb && wb_we) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wr_bound", 64'(n < budget), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_count"}, 64'(writes.size() - base), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      check({tag, "_byte"}, (base + i < writes.size()) ? 64'(writes[base + i]) : 64'hDEAD,
            64'(exp_w[i]));
    end
  endtask

  initial begin
    int base;
    int base_r;
    int cnt;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tick(2);

    // Reset state, with requests pending so a leaky grant would show.
    req_valid = 2'b11;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_cyc", 64'(wb_cyc), 64'd0);
    check("rst_stb", 64'(wb_stb), 64'd0);
    check("rst_we", 64'(wb_we), 64'd0);
    check("rst_adr", wb_adr, 64'd0);
    check("rst_dat", wb_wdat, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    req_valid = '0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Single byte: exact cycle-by-cycle bus sequence.
    base = writes.size();
    src0.push_back(8'h41);
    feed(20);
    check("sb_busy0", 64'(busy), 64'd1);
    check("sb_stb0", 64'(wb_stb), 64'd0);
    tick(1);
    check("sb_rd_stb", 64'(wb_stb), 64'd1);
    check("sb_rd_cyc", 64'(wb_cyc), 64'd1);
    check("sb_rd_we", 64'(wb_we), 64'd0);
    check("sb_rd_adr", wb_adr, 64'h00);
    tick(1);
    check("sb_rd_hold", 64'(wb_stb), 64'd1);
    tick(1);
    check("sb_gap_stb", 64'(wb_stb), 64'd0);
    check("sb_gap_cyc", 64'(wb_cyc), 64'd0);
    tick(1);
    check("sb_wr_stb", 64'(wb_stb), 64'd1);
    check("sb_wr_we", 64'(wb_we), 64'd1);
    check("sb_wr_adr", wb_adr, 64'h10);
    check("sb_wr_dat", wb_wdat, 64'h41);
    tick(2);
    check("sb_gapwr_stb", 64'(wb_stb), 64'd0);
    check("sb_gapwr_busy", 64'(busy), 64'd1);
    tick(1);
    check("sb_idle_busy", 64'(busy), 64'd0);
    exp_w = '{8'h41};
    check_writes("sb", base);

    // Busy polling: three busy STAT reads, then idle.
    base   = writes.size();
    base_r = stat_reads;
    busy_until = stat_reads + 3;
    src1.push_back(8'h5A);
    feed(20);
    wait_idle(300);
    check("poll_reads", 64'(stat_reads - base_r), 64'd4);
    exp_w = '{8'h5A};
    check_writes("poll", base);

    // Fairness with both requesters continuously valid.
    do_reset();
    base = writes.size();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(8'hA0 + 8'(i));
      src1.push_back(8'hB0 + 8'(i));
    end
    feed(40);
    check("fair_ngrants", 64'(grants.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("fair_grant", (i < grants.size()) ? 64'(grants[i]) : 64'hF, 64'(i % 2));
    end
    wait_idle(600);
    exp_w = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    check_writes("fair", base);

    // Full FIFO while the UART reports busy.
    do_reset();
    base = writes.size();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src0.push_back(8'hC0 + 8'(i));
      src1.push_back(8'hD0 + 8'(i));
    end
    feed(40);
    req_valid = 2'b11;
    req_data  = 16'hE1E0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    check("full_busy", 64'(busy), 64'd1);
    check("full_nowrite", 64'(writes.size() - base), 64'd0);
    req_valid = '0;
    src0.push_back(8'hE0);
    src1.push_back(8'hE1);
    hold_busy = 1'b0;
    feed(400);
    wait_idle(1000);
    exp_w = '{8'hC0, 8'hD0, 8'hC1, 8'hD1, 8'hC2, 8'hD2, 8'hC3, 8'hD3, 8'hE0, 8'hE1};
    check_writes("full", base);

    // Bus error on a DATA write drops that byte only.
    do_reset();
    base = writes.size();
    err_write_idx = wr_attempts;
    src0.push_back(8'h55);
    src0.push_back(8'h66);
    feed(20);
    wait_idle(300);
    err_write_idx = -1;
    check("berr_err", 64'(err), 64'd1);
    exp_w = '{8'h66};
    check_writes("berr", base);

    // Ack timeout: strobe high for exactly 255 cycles.
    do_reset();
    check("tmo_err0", 64'(err), 64'd0);
    base = writes.size();
    no_ack_wr = 1'b1;
    src0.push_back(8'h77);
    feed(20);
    wait_wr(50);
    cnt = 0;
    while (wb_stb && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_cycles", 64'(cnt), 64'd255);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_stb", 64'(wb_stb), 64'd0);
    wait_idle(20);
    check("tmo_nowrite", 64'(writes.size() - base), 64'd0);

    // Reset while a DATA write is on the bus.
    src0.push_back(8'h88);
    feed(20);
    wait_wr(50);
    check("rmw_err_pre", 64'(err), 64'd1);
    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_data  = 16'h0099;
    #1;
    check("rmw_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = '0;
    check("rmw_stb", 64'(wb_stb), 64'd0);
    check("rmw_cyc", 64'(wb_cyc), 64'd0);
    check("rmw_busy", 64'(busy), 64'd0);
    check("rmw_err", 64'(err), 64'd0);
    rst_n     = 1'b1;
    no_ack_wr = 1'b0;
    tick(10);
    check("rmw_quiet_cyc", 64'(wb_cyc), 64'd0);
    check("rmw_quiet_busy", 64'(busy), 64'd0);
    check("rmw_nowrite", 64'(writes.size() - base), 64'd0);

`ifdef UART_SEQ_CRLF_EN
    base = writes.size();
    src0.push_back(8'h0A);
    feed(20);
    wait_idle(300);
    exp_w = '{8'h0D, 8'h0A};
    check_writes("crlf", base);
`endif

    check("gap_viol", 64'(gap_viol), 64'd0);
    check("bad_bus", 64'(bad_bus), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
